// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI transfer sequencer
package spi_pkg;

    typedef enum logic [3:0] {
        S_INIT  = 4'b0001,
        S_IDLE  = 4'b0010,
        S_SETUP = 4'b0100,
        S_WAIT  = 4'b1000
    } state_t;

    localparam int TIMER_W     = 16;
    localparam int SYNC_STAGES = 2;
    localparam int INIT_CYCLES = 3;

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - show-ahead synchronous FIFO with occupancy level
module spi_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    // Head is forced to zero when empty so the output never shows stale storage.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - buffers words and drives the SPI master's toggle handshake
module spi_xfer_sequencer
    import spi_pkg::*;
#(
    parameter int TRAN_WIDTH     = 8,
    parameter int FIFO_AW        = 2,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                  c_Clk_High,
    input  logic                  i_Rst_n,
    input  logic                  i_Tx_Valid,
    input  logic [TRAN_WIDTH-1:0] i_Tx_Data,
    output logic                  o_Tx_Ready,
    output logic                  o_Rx_Valid,
    output logic [TRAN_WIDTH-1:0] o_Rx_Data,
    input  logic                  i_Rx_Ready,
    output logic [FIFO_AW:0]      o_Tx_Level,
    output logic [FIFO_AW:0]      o_Rx_Level,
    output logic                  o_Busy,
    output logic                  o_Timeout_Err,
    input  logic                  i_Err_Clear,
    output logic                  o_SPI_Send_Sync,
    output logic [TRAN_WIDTH-1:0] o_SPI_Send_Data,
    input  logic                  i_SPI_Receive_Sync,
    input  logic [TRAN_WIDTH-1:0] i_SPI_Receive_Data
);

    localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT_CYCLES);

    state_t                  state_q, state_d;
    logic [1:0]              init_cnt_q, init_cnt_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    sync_s2;
    logic                    ref_q, ref_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic                    send_sync_q, send_sync_d;
    logic [TRAN_WIDTH-1:0]   send_data_q, send_data_d;
    logic                    err_q, err_d;
    logic                    busy_q;

    logic                    tx_push, tx_pop, tx_full, tx_empty;
    logic [TRAN_WIDTH-1:0]   tx_head;
    logic                    rx_push, rx_full, rx_empty;

    assign sync_s2 = sync_q[SYNC_STAGES-1];

    // TX intake stays closed while the FSM is still initialising.
    assign o_Tx_Ready      = ~tx_full & (state_q != S_INIT);
    assign tx_push         = i_Tx_Valid & o_Tx_Ready;
    assign o_Rx_Valid      = ~rx_empty;
    assign o_Busy          = busy_q;
    assign o_Timeout_Err   = err_q;
    assign o_SPI_Send_Sync = send_sync_q;
    assign o_SPI_Send_Data = send_data_q;

    spi_sync_fifo #(.W(TRAN_WIDTH), .AW(FIFO_AW)) u_tx_fifo (
        .clk_i   (c_Clk_High),
        .rst_ni  (i_Rst_n),
        .push_i  (tx_push),
        .wdata_i (i_Tx_Data),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (o_Tx_Level)
    );

    spi_sync_fifo #(.W(TRAN_WIDTH), .AW(FIFO_AW)) u_rx_fifo (
        .clk_i   (c_Clk_High),
        .rst_ni  (i_Rst_n),
        .push_i  (rx_push),
        .wdata_i (i_SPI_Receive_Data),
        .pop_i   (i_Rx_Ready),
        .rdata_o (o_Rx_Data),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (o_Rx_Level)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        ref_d       = ref_q;
        timer_d     = timer_q;
        send_sync_d = send_sync_q;
        send_data_d = send_data_q;
        err_d       = err_q;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;

        if (i_Err_Clear) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_INIT: begin
                ref_d = sync_s2;
                if (init_cnt_q == 2'(INIT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                // Tracking the synchroniser here swallows any stale or late toggle.
                ref_d = sync_s2;
                if (!tx_empty && !rx_full) begin
                    tx_pop      = 1'b1;
                    send_data_d = tx_head;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                send_sync_d = ~send_sync_q;
                timer_d     = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // Compare the post-increment count: fires after TIMEOUT_CYCLES wait cycles.
                timer_d = timer_q + TIMER_W'(1);
                if (sync_s2 != ref_q) begin
                    rx_push = 1'b1;
                    ref_d   = sync_s2;
                    state_d = S_IDLE;
                end else if (timer_d == TIMEOUT_VAL) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge c_Clk_High or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            sync_q      <= '0;
            ref_q       <= 1'b0;
            timer_q     <= '0;
            send_sync_q <= 1'b0;
            send_data_q <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], i_SPI_Receive_Sync};
            ref_q       <= ref_d;
            timer_q     <= timer_d;
            send_sync_q <= send_sync_d;
            send_data_q <= send_data_d;
            err_q       <= err_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - directed/randomized bench with an SPI master response model
module tb_spi_xfer_sequencer;

    localparam int TW = 8;
    localparam int AW = 2;
    localparam int TO = 100;
    localparam int M_NORMAL = 0;
    localparam int M_SILENT = 1;
    localparam int M_LATE   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_Tx_Valid = 1'b0;
    logic [TW-1:0] i_Tx_Data = '0;
    logic          o_Tx_Ready;
    logic          o_Rx_Valid;
    logic [TW-1:0] o_Rx_Data;
    logic          i_Rx_Ready = 1'b0;
    logic [AW:0]   o_Tx_Level;
    logic [AW:0]   o_Rx_Level;
    logic          o_Busy;
    logic          o_Timeout_Err;
    logic          i_Err_Clear = 1'b0;
    logic          o_SPI_Send_Sync;
    logic [TW-1:0] o_SPI_Send_Data;
    logic          i_SPI_Receive_Sync;
    logic [TW-1:0] i_SPI_Receive_Data;

    int            vectors = 0;
    int            miscompares = 0;
    int            launches = 0;
    int            rx_popped = 0;
    int            mode = M_NORMAL;
    int            fixed_dly = 0;
    logic [TW-1:0] key = '0;
    time           t_push = 0;
    time           t_launch = 0;
    logic [TW-1:0] tx_exp[$];
    logic [TW-1:0] rx_exp[$];

    spi_xfer_sequencer #(.TRAN_WIDTH(TW), .FIFO_AW(AW), .TIMEOUT_CYCLES(TO)) dut (
        .c_Clk_High         (clk),
        .i_Rst_n            (rst_n),
        .i_Tx_Valid         (i_Tx_Valid),
        .i_Tx_Data          (i_Tx_Data),
        .o_Tx_Ready         (o_Tx_Ready),
        .o_Rx_Valid         (o_Rx_Valid),
        .o_Rx_Data          (o_Rx_Data),
        .i_Rx_Ready         (i_Rx_Ready),
        .o_Tx_Level         (o_Tx_Level),
        .o_Rx_Level         (o_Rx_Level),
        .o_Busy             (o_Busy),
        .o_Timeout_Err      (o_Timeout_Err),
        .i_Err_Clear        (i_Err_Clear),
        .o_SPI_Send_Sync    (o_SPI_Send_Sync),
        .o_SPI_Send_Data    (o_SPI_Send_Data),
        .i_SPI_Receive_Sync (i_SPI_Receive_Sync),
        .i_SPI_Receive_Data (i_SPI_Receive_Data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Caller must be positioned just after a rising edge.
    task automatic push(input logic [TW-1:0] w, input int tries, output bit acc);
        acc = 1'b0;
        i_Tx_Valid = 1'b1;
        i_Tx_Data  = w;
        for (int k = 0; k < tries && !acc; k++) begin
            @(negedge clk);
            acc = o_Tx_Ready;
            @(posedge clk);
            if (acc) begin
                t_push = $time;
                tx_exp.push_back(w);
            end
            #1;
        end
        i_Tx_Valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_tx_ready"}, o_Tx_Ready, 0);
        chk({pfx, "_rx_valid"}, o_Rx_Valid, 0);
        chk({pfx, "_rx_data"}, o_Rx_Data, 0);
        chk({pfx, "_tx_level"}, o_Tx_Level, 0);
        chk({pfx, "_rx_level"}, o_Rx_Level, 0);
        chk({pfx, "_busy"}, o_Busy, 0);
        chk({pfx, "_err"}, o_Timeout_Err, 0);
        chk({pfx, "_send_sync"}, o_SPI_Send_Sync, 0);
        chk({pfx, "_send_data"}, o_SPI_Send_Data, 0);
    endtask

    // SPI master model: answers each send toggle with (word ^ key) after a delay.
    initial begin : master
        logic          last_seen;
        logic [TW-1:0] sent;
        logic [TW-1:0] resp;
        logic [31:0]   e;
        int            d;
        last_seen = 1'b0;
        i_SPI_Receive_Sync = 1'b0;
        i_SPI_Receive_Data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_seen = 1'b0;
                i_SPI_Receive_Sync = 1'b1;
            end else if (o_SPI_Send_Sync !== last_seen) begin
                last_seen = o_SPI_Send_Sync;
                launches++;
                t_launch = $time;
                sent = o_SPI_Send_Data;
                e = (tx_exp.size() > 0) ? 32'(tx_exp.pop_front()) : 32'hdeadbeef;
                chk("send_data", 32'(sent), e);
                if (mode != M_SILENT) begin
                    if (mode == M_LATE)     d = TO + 10;
                    else if (fixed_dly > 0) d = fixed_dly;
                    else                    d = int'($urandom_range(2, 20));
                    repeat (d) @(negedge clk);
                    chk("send_data_hold", 32'(o_SPI_Send_Data), 32'(sent));
                    resp = sent ^ key;
                    if (mode == M_NORMAL) rx_exp.push_back(resp);
                    i_SPI_Receive_Data = resp;
                    i_SPI_Receive_Sync = ~i_SPI_Receive_Sync;
                end
            end
        end
    end

    initial begin : consumer
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && i_Rx_Ready && o_Rx_Valid) begin
                e = (rx_exp.size() > 0) ? 32'(rx_exp.pop_front()) : 32'hdeadbeef;
                chk("rx_word", 32'(o_Rx_Data), e);
                rx_popped++;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit   acc;
        int   base;
        int   pr;
        logic [TW-1:0] w;

        repeat (3) @(negedge clk);
        chk_reset_outputs("rst0");
        align();
        rst_n = 1'b1;

        // single word, master returns 0xA5 ^ 0x99 = 0x3C
        key = 8'h99;
        push(8'hA5, 20, acc);
        chk("t1_accept", acc, 1);
        for (int n = 0; n < 100 && !o_Rx_Valid; n++) @(negedge clk);
        chk("t1_rx_valid", o_Rx_Valid, 1);
        chk("t1_rx_data", o_Rx_Data, 8'h3C);
        chk("t1_tx_level", o_Tx_Level, 0);
        chk("t1_launches", launches, 1);
        chk("t1_latency", 32'(t_launch - t_push), 25);
        align();
        i_Rx_Ready = 1'b1;
        align();
        i_Rx_Ready = 1'b0;
        chk("t1_popped", rx_popped, 1);

        // burst while a slow pilot transfer holds the FSM in wait
        key = 8'h00;
        i_Rx_Ready = 1'b1;
        fixed_dly = 40;
        push(8'hF0, 5, acc);
        chk("t2_pilot", acc, 1);
        for (int i = 1; i <= 4; i++) begin
            push(8'(i), 1, acc);
            chk("t2_accept", acc, 1);
        end
        push(8'h05, 1, acc);
        chk("t2_fifth_refused", acc, 0);
        chk("t2_tx_level_full", o_Tx_Level, 4);
        chk("t2_busy", o_Busy, 1);
        fixed_dly = 0;
        for (int n = 0; n < 2000 && rx_popped < 6; n++) @(negedge clk);
        chk("t2_popped", rx_popped, 6);
        chk("t2_tx_level", o_Tx_Level, 0);

        // RX backpressure: only four transfers fit
        align();
        i_Rx_Ready = 1'b0;
        key = 8'h5A;
        base = launches;
        pr = rx_popped;
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            push(w, 100, acc);
            chk("t3_accept", acc, 1);
        end
        for (int n = 0; n < 1000 && o_Rx_Level != 4; n++) @(negedge clk);
        repeat (50) @(negedge clk);
        chk("t3_launches_blocked", launches - base, 4);
        chk("t3_rx_level", o_Rx_Level, 4);
        chk("t3_idle", o_Busy, 0);
        chk("t3_tx_level", o_Tx_Level, 2);
        align();
        i_Rx_Ready = 1'b1;
        for (int n = 0; n < 1000 && rx_popped < pr + 6; n++) @(negedge clk);
        chk("t3_popped", rx_popped - pr, 6);
        chk("t3_launches_all", launches - base, 6);

        // timeout: master never answers
        align();
        mode = M_SILENT;
        base = launches;
        push(8'($urandom), 20, acc);
        for (int n = 0; n < 400 && !o_Timeout_Err; n++) @(negedge clk);
        chk("t4_err", o_Timeout_Err, 1);
        chk("t4_err_delay", 32'($time - t_launch), TO * 10);
        chk("t4_rx_level", o_Rx_Level, 0);
        chk("t4_busy", o_Busy, 0);
        chk("t4_launches", launches - base, 1);
        align();
        mode = M_NORMAL;
        key = 8'h0F;
        pr = rx_popped;
        push(8'($urandom), 20, acc);
        for (int n = 0; n < 200 && rx_popped == pr; n++) @(negedge clk);
        chk("t4_next_word", rx_popped - pr, 1);
        chk("t4_err_sticky", o_Timeout_Err, 1);
        align();
        i_Err_Clear = 1'b1;
        align();
        i_Err_Clear = 1'b0;
        chk("t4_err_cleared", o_Timeout_Err, 0);

        // late toggle after timeout is swallowed
        mode = M_LATE;
        base = launches;
        pr = rx_popped;
        push(8'($urandom), 20, acc);
        for (int n = 0; n < 400 && !o_Timeout_Err; n++) @(negedge clk);
        chk("t5_err", o_Timeout_Err, 1);
        chk("t5_err_delay", 32'($time - t_launch), TO * 10);
        repeat (20) @(negedge clk);
        chk("t5_rx_level", o_Rx_Level, 0);
        chk("t5_rx_valid", o_Rx_Valid, 0);
        chk("t5_busy", o_Busy, 0);
        chk("t5_launches", launches - base, 1);
        align();
        i_Err_Clear = 1'b1;
        align();
        i_Err_Clear = 1'b0;
        mode = M_NORMAL;
        key = 8'hC3;
        push(8'($urandom), 20, acc);
        for (int n = 0; n < 200 && rx_popped == pr; n++) @(negedge clk);
        chk("t5_next_word", rx_popped - pr, 1);
        chk("t5_err_clear", o_Timeout_Err, 0);

        // reset with receive-sync held high by the master model
        align();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst1");
        chk("rst1_rx_sync_high", i_SPI_Receive_Sync, 1);
        align();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_rx_level", o_Rx_Level, 0);
        chk("t6_rx_valid", o_Rx_Valid, 0);
        chk("t6_busy", o_Busy, 0);
        chk("t6_send_sync", o_SPI_Send_Sync, 0);
        align();
        key = 8'h77;
        base = launches;
        pr = rx_popped;
        push(8'($urandom), 20, acc);
        for (int n = 0; n < 200 && rx_popped == pr; n++) @(negedge clk);
        chk("t6_first_word", rx_popped - pr, 1);
        chk("t6_launches", launches - base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
